branch_target_buffer_assoc: RTL and testbench

//  Tagged, set-associative branch target buffer for the fetch stage. Replaces the direct-mapped, untagged buffer.

---
 rtl/dp_types_pkg.sv | 18 +
 rtl/btb_plru.sv | 26 ++
 rtl/branch_target_buffer_assoc.sv | 129 ++++++++++++
 tb/tb_branch_target_buffer_assoc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_types_pkg.sv
// dp_types_pkg: shared datapath types plus branch target buffer defaults and PC field helpers.
package dp_types_pkg;

   typedef logic [31:0] word_t;

   localparam int BTB_DEF_SETS  = 64;
   localparam int BTB_DEF_WAYS  = 2;
   localparam int BTB_DEF_CTR_W = 2;

   function automatic word_t btb_index(input word_t pc, input int unsigned index_w);
      return (pc >> 2) & ((word_t'(1) << index_w) - word_t'(1));
   endfunction

   function automatic word_t btb_tag(input word_t pc, input int unsigned index_w);
      return pc >> (index_w + 2);
   endfunction

endpackage

// File: rtl/btb_plru.sv
// btb_plru: combinational tree pseudo-LRU for one set; node bits point toward the least-recent side.
module btb_plru #(
   parameter int WAYS = 2,
   localparam int PW = (WAYS > 1) ? WAYS - 1 : 1,
   localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [PW-1:0] bits,
   input  logic [WW-1:0] touch,
   output logic [PW-1:0] next_bits,
   output logic [WW-1:0] victim
);

   generate
      if (WAYS == 4) begin : g_four
         assign victim    = {bits[0], bits[0] ? bits[2] : bits[1]};
         assign next_bits = {touch[1] ? ~touch[0] : bits[2], touch[1] ? bits[1] : ~touch[0], ~touch[1]};
      end else if (WAYS == 2) begin : g_two
         assign victim    = bits;
         assign next_bits = ~touch;
      end else begin : g_one
         assign victim    = touch & 1'b0;
         assign next_bits = bits;
      end
   endgenerate

endmodule

// File: rtl/branch_target_buffer_assoc.sv
// branch_target_buffer_assoc: tagged set-associative BTB with combinational lookup,
// resolve-stage update, tree-PLRU allocation and a set-by-set flush walker.
module branch_target_buffer_assoc
   import dp_types_pkg::*;
#(
   parameter int SETS  = BTB_DEF_SETS,
   parameter int WAYS  = BTB_DEF_WAYS,
   parameter int CTR_W = BTB_DEF_CTR_W
) (
   input  logic  CLK,
   input  logic  RST,
   input  word_t lookup_pc,
   output logic  pred_hit,
   output logic  pred_taken,
   output word_t pred_target,
   input  logic  upd_en,
   input  word_t upd_pc,
   input  logic  upd_taken,
   input  word_t upd_target,
   input  logic  flush,
   output logic  busy
);

   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;
   localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
   localparam logic [IW:0] WALK_END = (IW + 1)'(SETS);

   logic [SETS-1:0]  valid  [WAYS];
   logic [TW-1:0]    tag    [WAYS][SETS];
   word_t            target [WAYS][SETS];
   logic [CTR_W-1:0] ctr    [WAYS][SETS];
   logic [PW-1:0]    plru   [SETS];
   logic [IW:0]      walk;

   logic [IW-1:0]    lidx, uidx;
   logic [TW-1:0]    ltag, utag;
   logic             l_hit, u_hit, inv_any;
   logic [WW-1:0]    l_way, u_way, inv_way, victim, alloc_way, touch;
   logic [PW-1:0]    plru_nxt;
   logic [CTR_W-1:0] ctr_cur, ctr_nxt;
   logic             do_upd, wr_hit, wr_alloc;

   assign lidx = IW'(btb_index(lookup_pc, IW));
   assign ltag = TW'(btb_tag(lookup_pc, IW));
   assign uidx = IW'(btb_index(upd_pc, IW));
   assign utag = TW'(btb_tag(upd_pc, IW));

   // Descending scan so the lowest matching / invalid way is the one left standing.
   always_comb begin
      l_hit   = 1'b0;
      l_way   = '0;
      u_hit   = 1'b0;
      u_way   = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[w][lidx] && tag[w][lidx] == ltag) begin
            l_hit = 1'b1;
            l_way = WW'(w);
         end
         if (valid[w][uidx] && tag[w][uidx] == utag) begin
            u_hit = 1'b1;
            u_way = WW'(w);
         end
         if (!valid[w][uidx]) begin
            inv_any = 1'b1;
            inv_way = WW'(w);
         end
      end
   end

   assign pred_hit    = l_hit & ~busy;
   assign pred_taken  = pred_hit & ctr[l_way][lidx][CTR_W-1];
   assign pred_target = pred_hit ? target[l_way][lidx] : '0;

   btb_plru #(.WAYS(WAYS)) u_plru (
      .bits      (plru[uidx]),
      .touch     (touch),
      .next_bits (plru_nxt),
      .victim    (victim)
   );

   assign alloc_way = inv_any ? inv_way : victim;
   assign touch     = u_hit ? u_way : alloc_way;
   assign ctr_cur   = ctr[u_way][uidx];
   assign ctr_nxt   = upd_taken ? ((ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + 1'b1)
                                : ((ctr_cur == '0) ? ctr_cur : ctr_cur - 1'b1);
   assign do_upd    = upd_en & ~busy & ~flush & ~RST;
   assign wr_hit    = do_upd & u_hit;
   assign wr_alloc  = do_upd & ~u_hit & upd_taken;

   always_ff @(posedge CLK) begin
      if (RST) begin
         busy <= 1'b0;
         walk <= '0;
         for (int w = 0; w < WAYS; w++) begin
            valid[w] <= '0;
            for (int s = 0; s < SETS; s++) ctr[w][s] <= '0;
         end
         for (int s = 0; s < SETS; s++) plru[s] <= '0;
      end else if (flush) begin
         busy <= 1'b1;
         walk <= '0;
      end else if (busy) begin
         for (int w = 0; w < WAYS; w++) valid[w][walk[IW-1:0]] <= 1'b0;
         plru[walk[IW-1:0]] <= '0;
         walk <= walk + 1'b1;
         busy <= (walk + 1'b1) != WALK_END;
      end else if (wr_hit) begin
         ctr[u_way][uidx] <= ctr_nxt;
         plru[uidx]       <= plru_nxt;
      end else if (wr_alloc) begin
         valid[alloc_way][uidx] <= 1'b1;
         ctr[alloc_way][uidx]   <= CTR_WEAK;
         plru[uidx]             <= plru_nxt;
      end
   end

   // Tag and target need no reset: they are only observed through a valid bit.
   always_ff @(posedge CLK) begin
      if (do_upd && upd_taken) target[touch][uidx] <= upd_target;
      if (wr_alloc) tag[alloc_way][uidx] <= utag;
   end

endmodule

// File: tb/tb_branch_target_buffer_assoc.sv
// tb_branch_target_buffer_assoc: directed and random stimulus checked against an LRU-ordered entry model.
module tb_branch_target_buffer_assoc;

   localparam int SETS  = 64;
   localparam int WAYS  = 2;
   localparam int CTR_W = 2;
   localparam int IW    = 6;
   localparam int CMAX  = (1 << CTR_W) - 1;

   logic        CLK = 1'b0;
   logic        RST, upd_en, upd_taken, flush;
   logic        pred_hit, pred_taken, busy;
   logic [31:0] lookup_pc, upd_pc, upd_target, pred_target;

   int checks = 0;
   int failures = 0;

   logic        mv   [SETS][WAYS];
   logic [31:0] mtag [SETS][WAYS];
   logic [31:0] mtgt [SETS][WAYS];
   int          mctr [SETS][WAYS];
   int          mage [SETS][WAYS];
   int          now = 0;
   int          busy_rem = 0;

   branch_target_buffer_assoc #(.SETS(SETS), .WAYS(WAYS), .CTR_W(CTR_W)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .lookup_pc   (lookup_pc),
      .pred_hit    (pred_hit),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_en      (upd_en),
      .upd_pc      (upd_pc),
      .upd_taken   (upd_taken),
      .upd_target  (upd_target),
      .flush       (flush),
      .busy        (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic m_clear();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
   endtask

   task automatic m_lookup(input logic [31:0] pc, output logic h, output logic t, output logic [31:0] tg);
      int s;
      s = int'((pc >> 2) % SETS);
      h = 1'b0; t = 1'b0; tg = '0;
      if (busy_rem == 0)
         for (int w = 0; w < WAYS; w++)
            if (!h && mv[s][w] && mtag[s][w] == (pc >> (IW + 2))) begin
               h  = 1'b1;
               t  = mctr[s][w] >= (1 << (CTR_W - 1));
               tg = mtgt[s][w];
            end
   endtask

   // Entries carry a last-use stamp; a full set evicts the oldest one.
   task automatic m_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      int s, hw, vw;
      s  = int'((pc >> 2) % SETS);
      hw = -1;
      for (int w = 0; w < WAYS; w++)
         if (hw < 0 && mv[s][w] && mtag[s][w] == (pc >> (IW + 2))) hw = w;
      now++;
      if (hw >= 0) begin
         mctr[s][hw] = tk ? ((mctr[s][hw] < CMAX) ? mctr[s][hw] + 1 : CMAX)
                          : ((mctr[s][hw] > 0) ? mctr[s][hw] - 1 : 0);
         if (tk) mtgt[s][hw] = tg;
         mage[s][hw] = now;
      end else if (tk) begin
         vw = -1;
         for (int w = 0; w < WAYS; w++) if (vw < 0 && !mv[s][w]) vw = w;
         if (vw < 0) begin
            vw = 0;
            for (int w = 1; w < WAYS; w++) if (mage[s][w] < mage[s][vw]) vw = w;
         end
         mv[s][vw]   = 1'b1;
         mtag[s][vw] = pc >> (IW + 2);
         mtgt[s][vw] = tg;
         mctr[s][vw] = 1 << (CTR_W - 1);
         mage[s][vw] = now;
      end
   endtask

   task automatic cyc(input logic [31:0] lpc, input logic ue, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utg, input logic fl, input string tag);
      logic eh, et;
      logic [31:0] eg;
      lookup_pc = lpc; upd_en = ue; upd_pc = upc; upd_taken = ut; upd_target = utg; flush = fl;
      #1;
      m_lookup(lpc, eh, et, eg);
      chk({tag, ".hit"}, 32'(pred_hit), 32'(eh));
      chk({tag, ".taken"}, 32'(pred_taken), 32'(et));
      chk({tag, ".target"}, pred_target, eg);
      chk({tag, ".busy"}, 32'(busy), 32'(busy_rem > 0));
      @(posedge CLK);
      if (fl) begin
         m_clear();
         busy_rem = SETS;
      end else if (busy_rem > 0) busy_rem--;
      else if (ue) m_update(upc, ut, utg);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input string tag);
      cyc(pc, 1'b1, pc, tk, tg, 1'b0, tag);
   endtask

   task automatic peek(input logic [31:0] pc);
      lookup_pc = pc; upd_en = 1'b0; flush = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; upd_en = 1'b0; flush = 1'b0;
      @(posedge CLK);
      m_clear();
      busy_rem = 0;
      #1;
      RST = 1'b0;
   endtask

   initial begin
      int bc;
      logic [31:0] pc;
      lookup_pc = '0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      do_reset();

      peek(32'h100);
      chk("rst.hit", 32'(pred_hit), 0);
      chk("rst.taken", 32'(pred_taken), 0);
      chk("rst.target", pred_target, 0);
      chk("rst.busy", 32'(busy), 0);

      upd(32'h100, 1'b1, 32'h200, "alloc_same_cycle");
      peek(32'h100);
      chk("alloc.hit", 32'(pred_hit), 1);
      chk("alloc.taken", 32'(pred_taken), 1);
      chk("alloc.target", pred_target, 32'h200);

      for (int i = 0; i < 3; i++) upd(32'h100, 1'b0, 32'h0, "sat_down");
      peek(32'h100);
      chk("sat_low.hit", 32'(pred_hit), 1);
      chk("sat_low.taken", 32'(pred_taken), 0);
      for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 32'h200, "sat_up");
      upd(32'h100, 1'b0, 32'h0, "sat_step1");
      peek(32'h100);
      chk("sat_high.taken", 32'(pred_taken), 1);
      upd(32'h100, 1'b0, 32'h0, "sat_step2");
      peek(32'h100);
      chk("sat_high2.taken", 32'(pred_taken), 0);
      chk("sat_high2.target", pred_target, 32'h200);

      do_reset();
      upd(32'h000, 1'b1, 32'hA0, "plru_a");
      upd(32'h100, 1'b1, 32'hB0, "plru_b");
      upd(32'h000, 1'b1, 32'hA0, "plru_touch_a");
      upd(32'h200, 1'b1, 32'hC0, "plru_c");
      peek(32'h000);
      chk("evict.a_hit", 32'(pred_hit), 1);
      chk("evict.a_target", pred_target, 32'hA0);
      peek(32'h200);
      chk("evict.c_hit", 32'(pred_hit), 1);
      chk("evict.c_target", pred_target, 32'hC0);
      peek(32'h100);
      chk("evict.b_miss", 32'(pred_hit), 0);

      upd(32'h300, 1'b0, 32'hD0, "nt_miss");
      peek(32'h300);
      chk("nt_miss.hit", 32'(pred_hit), 0);
      peek(32'h000);
      chk("nt_miss.a_kept", 32'(pred_hit), 1);
      peek(32'h200);
      chk("nt_miss.c_kept", 32'(pred_hit), 1);

      for (int i = 0; i < SETS; i++) upd(32'h1_0000 | 32'(i << 2), 1'b1, 32'h4000 + 32'(i), "fill");
      cyc(32'h1_0000, 1'b1, 32'h1_0004, 1'b1, 32'h55, 1'b1, "flush_req");
      bc = 0;
      for (int k = 1; k <= SETS + 10; k++) begin
         if (busy) bc++;
         pc = 32'h1_0000 | 32'($urandom_range(0, SETS - 1) << 2);
         cyc(pc, k <= SETS + 5, pc, 1'b1, 32'h77, k == 5, "walk");
      end
      chk("flush.busy_cycles", 32'(bc), 32'(SETS + 5));
      for (int i = 0; i < SETS; i += 7) begin
         peek(32'h1_0000 | 32'(i << 2));
         chk("flush.after_miss", 32'(pred_hit), 0);
      end

      upd(32'h000, 1'b1, 32'hA0, "rst_walk_fill");
      cyc(32'h000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "rst_walk_flush");
      for (int i = 0; i < 3; i++) cyc(32'h000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rst_walk");
      do_reset();
      peek(32'h000);
      chk("rst_walk.busy", 32'(busy), 0);
      chk("rst_walk.hit", 32'(pred_hit), 0);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] lp, up;
         int idx_l, idx_u;
         idx_l = ($urandom_range(0, 2) == 2) ? SETS - 1 : $urandom_range(0, 1);
         idx_u = ($urandom_range(0, 2) == 2) ? SETS - 1 : $urandom_range(0, 1);
         lp = 32'($urandom_range(0, 3) << (IW + 2)) | 32'(idx_l << 2) | 32'($urandom_range(0, 3));
         up = 32'($urandom_range(0, 3) << (IW + 2)) | 32'(idx_u << 2) | 32'($urandom_range(0, 3));
         cyc(lp, $urandom_range(0, 3) != 0, up, $urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 999) < 3, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
